// File: rtl/screen_scanner.sv
// screen_scanner: raster scan-out timing, blanked RGB pipeline and frame/vblank ticks.
// Counters step on a divided pixel enable; video outputs lag the counters by one pixel.
module screen_scanner #(
    parameter int SCR_W   = 400,
    parameter int SCR_H   = 700,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 48,
    parameter int H_BP    = 40,
    parameter int V_FP    = 3,
    parameter int V_SYNC  = 4,
    parameter int V_BP    = 13,
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [23:0] rgb_in,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [23:0] rgb_out,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start,
    output logic        vblank_tick
);
    localparam int H_TOTAL = SCR_W + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = SCR_H + V_FP + V_SYNC + V_BP;
    localparam int DW      = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div_cnt;
    logic          pix_en, active, x_last, y_last, hs_on, vs_on;

    assign pix_en = run && div_cnt == DW'(CLK_DIV - 1);
    assign active = pix_x < 10'(SCR_W) && pix_y < 10'(SCR_H);
    assign x_last = pix_x == 10'(H_TOTAL - 1);
    assign y_last = pix_y == 10'(V_TOTAL - 1);
    assign hs_on  = pix_x >= 10'(SCR_W + H_FP) && pix_x <= 10'(SCR_W + H_FP + H_SYNC - 1);
    assign vs_on  = pix_y >= 10'(SCR_H + V_FP) && pix_y <= 10'(SCR_H + V_FP + V_SYNC - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt     <= '0;
            pix_x       <= '0;
            pix_y       <= '0;
            rgb_out     <= '0;
            de          <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
            vblank_tick <= 1'b0;
        end else if (!run) begin
            div_cnt     <= '0;
            pix_x       <= '0;
            pix_y       <= '0;
            rgb_out     <= '0;
            de          <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
            vblank_tick <= 1'b0;
        end else begin
            div_cnt     <= pix_en ? '0 : DW'(div_cnt + 1'b1);
            frame_start <= pix_en && pix_x == '0 && pix_y == '0;
            // last pixel of the last visible line: the next line is the first blank one
            vblank_tick <= pix_en && x_last && pix_y == 10'(SCR_H - 1);
            if (pix_en) begin
                pix_x   <= x_last ? '0 : pix_x + 10'd1;
                if (x_last)
                    pix_y <= y_last ? '0 : pix_y + 10'd1;
                de      <= active;
                rgb_out <= active ? rgb_in : 24'h0;
                hsync   <= !hs_on;
                vsync   <= !vs_on;
            end
        end
    end
endmodule
